// File: rtl/msg_pkg.sv
// Shared message-layer definitions: FSM state encoding and default framing constants,
// used by both the receive-side assembler and the transmit-side message FSM.
package msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_READY   = 2'b10,
        ST_DISCARD = 2'b11
    } msg_state_e;

    localparam int          MSG_MAX_LEN   = 16;
    localparam logic [7:0]  MSG_TERM_CHAR = 8'h0D;

endpackage

// File: rtl/msg_assembler_if.sv
// Receive/consumer bus of the message assembler; slave modport is the assembler side.
interface msg_assembler_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_err;
    logic          rd_en;
    logic          msg_ready;
    logic [LW-1:0] msg_len;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          overflow;
    logic          frame_err;
    logic          rx_drop;
    logic          timeout;

    modport slave (
        input  rx_valid, rx_data, rx_err, rd_en,
        output msg_ready, msg_len, rd_data, rd_valid,
               overflow, frame_err, rx_drop, timeout
    );

    modport master (
        output rx_valid, rx_data, rx_err, rd_en,
        input  msg_ready, msg_len, rd_data, rd_valid,
               overflow, frame_err, rx_drop, timeout
    );
endinterface

// File: rtl/msg_buffer.sv
// DEPTH x 8 simple dual-port payload store: one write port, registered read port.
module msg_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_data_r;

    // Write port; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset so the popped-byte output starts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/msg_assembler.sv
// Assembles TERM_CHAR-terminated messages from a UART byte stream and lets a consumer pop them.
// Optional inter-byte idle timeout in COLLECT is built only when MSG_RX_TIMEOUT_EN is defined.
module msg_assembler
    import msg_pkg::*;
#(
    parameter int         MAX_LEN     = MSG_MAX_LEN,
    parameter logic [7:0] TERM_CHAR   = MSG_TERM_CHAR,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    msg_assembler_if.slave    bus
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);

    msg_state_e    state_r, state_s;
    logic [CW-1:0] count_r, count_s;
    logic [CW-1:0] rd_ptr_r, rd_ptr_s;
    logic          we_s, re_s, is_term_s, timeout_hit_s;
    logic          overflow_s, frame_err_s, rx_drop_s, timeout_s;
    logic          msg_ready_r, rd_valid_r;
    logic [CW-1:0] msg_len_r;
    logic          overflow_r, frame_err_r, rx_drop_r, timeout_r;

    assign is_term_s = (bus.rx_data == TERM_CHAR);

`ifdef MSG_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt_r;

    // Idle-cycle counter: runs only while collecting and no byte or error arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_COLLECT && !bus.rx_valid && !bus.rx_err && !timeout_hit_s) begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end else begin
            idle_cnt_r <= {TW{1'b0}};
        end
    end

    assign timeout_hit_s = (idle_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and event decode; a framing error always beats a same-cycle byte
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        rd_ptr_s    = rd_ptr_r;
        we_s        = 1'b0;
        re_s        = 1'b0;
        overflow_s  = 1'b0;
        frame_err_s = 1'b0;
        rx_drop_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.rx_err) begin
                    frame_err_s = 1'b1;
                    state_s     = ST_DISCARD;
                end else if (bus.rx_valid && !is_term_s) begin
                    we_s    = 1'b1;
                    count_s = CW'(1);
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (bus.rx_err) begin
                    frame_err_s = 1'b1;
                    count_s     = {CW{1'b0}};
                    state_s     = ST_DISCARD;
                end else if (bus.rx_valid) begin
                    if (is_term_s) begin
                        rd_ptr_s = {CW{1'b0}};
                        state_s  = ST_READY;
                    end else if (count_r < CW'(MAX_LEN)) begin
                        we_s    = 1'b1;
                        count_s = count_r + CW'(1);
                    end else begin
                        overflow_s = 1'b1;
                        count_s    = {CW{1'b0}};
                        state_s    = ST_DISCARD;
                    end
                end else if (timeout_hit_s) begin
                    timeout_s = 1'b1;
                    count_s   = {CW{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_READY: begin
                rx_drop_s = bus.rx_valid;
                if (bus.rd_en) begin
                    re_s = 1'b1;
                    if (rd_ptr_r == count_r - CW'(1)) begin
                        rd_ptr_s = {CW{1'b0}};
                        count_s  = {CW{1'b0}};
                        state_s  = ST_IDLE;
                    end else begin
                        rd_ptr_s = rd_ptr_r + CW'(1);
                    end
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_DISCARD: begin
                if (bus.rx_valid && !bus.rx_err && is_term_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                count_s  = {CW{1'b0}};
                rd_ptr_s = {CW{1'b0}};
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            rd_ptr_r    <= {CW{1'b0}};
            msg_ready_r <= 1'b0;
            msg_len_r   <= {CW{1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_drop_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            rd_ptr_r    <= rd_ptr_s;
            msg_ready_r <= (state_s == ST_READY);
            msg_len_r   <= (state_s == ST_READY) ? count_s : {CW{1'b0}};
            rd_valid_r  <= re_s;
            overflow_r  <= overflow_s;
            frame_err_r <= frame_err_s;
            rx_drop_r   <= rx_drop_s;
            timeout_r   <= timeout_s;
        end
    end

    msg_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (we_s),
        .wr_addr (count_r[AW-1:0]),
        .wr_data (bus.rx_data),
        .rd_en   (re_s),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (bus.rd_data)
    );

    assign bus.msg_ready = msg_ready_r;
    assign bus.msg_len   = msg_len_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.overflow  = overflow_r;
    assign bus.frame_err = frame_err_r;
    assign bus.rx_drop   = rx_drop_r;
    assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler: directed scenarios plus randomized traffic against a queue model.
module tb_msg_assembler;
    import msg_pkg::*;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] TERM    = 8'h0D;
    localparam int         TO_CYC  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    msg_assembler_if #(.MAX_LEN(MAX_LEN)) bus ();

    msg_assembler #(.MAX_LEN(MAX_LEN), .TERM_CHAR(TERM), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the message being built, the held message, discard flag
    logic [7:0] cur_q [$];
    logic [7:0] held_q [$];
    int         held_len;
    bit         disc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit e);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.rx_err   = e;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == TERM) b = 8'h41;
        return b;
    endfunction

    task automatic model_rx(input bit v, input logic [7:0] d, input bit e,
                            output bit ovf, output bit fe, output bit drop);
        ovf = 1'b0; fe = 1'b0; drop = 1'b0;
        if (held_q.size() != 0) begin
            drop = v;
        end else if (e) begin
            if (!disc) begin
                fe = 1'b1; disc = 1'b1; cur_q.delete();
            end
        end else if (v) begin
            if (disc) begin
                if (d == TERM) disc = 1'b0;
            end else if (d == TERM) begin
                if (cur_q.size() != 0) begin
                    held_q = cur_q; held_len = cur_q.size(); cur_q.delete();
                end
            end else if (cur_q.size() == MAX_LEN) begin
                ovf = 1'b1; disc = 1'b1; cur_q.delete();
            end else begin
                cur_q.push_back(d);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({bus.msg_ready, bus.msg_len, bus.rd_valid, bus.rd_data, bus.overflow,
             bus.frame_err, bus.rx_drop, bus.timeout} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%0b len=%0d rdv=%0b rdd=%h ovf=%0b fe=%0b drop=%0b to=%0b, want all 0",
                     bus.msg_ready, bus.msg_len, bus.rd_valid, bus.rd_data, bus.overflow,
                     bus.frame_err, bus.rx_drop, bus.timeout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hi();
        drive(1'b1, 8'h48, 1'b0);
        drive(1'b1, 8'h49, 1'b0);
        drive(1'b1, TERM, 1'b0);
        tests++;
        if ({bus.msg_ready, bus.msg_len} !== {1'b1, 5'd2}) begin
            fails++;
            $display("FAIL hi_ready: got ready=%0b len=%0d, want 1/2", bus.msg_ready, bus.msg_len);
        end
        pop();
        tests++;
        if ({bus.rd_valid, bus.rd_data, bus.msg_ready} !== {1'b1, 8'h48, 1'b1}) begin
            fails++;
            $display("FAIL hi_pop0: got rdv=%0b data=%h ready=%0b, want 1/48/1", bus.rd_valid, bus.rd_data, bus.msg_ready);
        end
        pop();
        tests++;
        if ({bus.rd_valid, bus.rd_data, bus.msg_ready, bus.msg_len} !== {1'b1, 8'h49, 1'b0, 5'd0}) begin
            fails++;
            $display("FAIL hi_pop1: got rdv=%0b data=%h ready=%0b len=%0d, want 1/49/0/0",
                     bus.rd_valid, bus.rd_data, bus.msg_ready, bus.msg_len);
        end
        pop();
        tests++;
        if (bus.rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_rd_en_ignored: got rdv=%0b, want 0", bus.rd_valid);
        end
    endtask

    task automatic test_overflow();
        int ovf_seen = 0;
        for (int i = 0; i < MAX_LEN + 1; i++) begin
            drive(1'b1, rand_byte(), 1'b0);
            if (bus.overflow === 1'b1) ovf_seen = ovf_seen + ((i == MAX_LEN) ? 1 : 100);
        end
        tests++;
        if (ovf_seen != 1) begin
            fails++;
            $display("FAIL overflow_pulse: got code=%0d, want 1 (single pulse on byte 17)", ovf_seen);
        end
        drive(1'b1, TERM, 1'b0);
        tick();
        tests++;
        if (bus.msg_ready !== 1'b0) begin
            fails++;
            $display("FAIL overflow_no_ready: got ready=%0b, want 0", bus.msg_ready);
        end
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b1, TERM, 1'b0);
        tests++;
        if ({bus.msg_ready, bus.msg_len} !== {1'b1, 5'd1}) begin
            fails++;
            $display("FAIL overflow_recover: got ready=%0b len=%0d, want 1/1", bus.msg_ready, bus.msg_len);
        end
        pop();
    endtask

    task automatic test_frame_err();
        int fe_seen = 0;
        int ready_seen = 0;
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        fe_seen += (bus.frame_err === 1'b1) ? 1 : 0;
        drive(1'b1, 8'h42, 1'b0);
        fe_seen += (bus.frame_err === 1'b1) ? 10 : 0;
        drive(1'b1, TERM, 1'b0);
        ready_seen += (bus.msg_ready === 1'b1) ? 1 : 0;
        drive(1'b1, 8'h43, 1'b0);
        ready_seen += (bus.msg_ready === 1'b1) ? 1 : 0;
        tests++;
        if (fe_seen != 1 || ready_seen != 0) begin
            fails++;
            $display("FAIL frame_err_pulse: got fe_code=%0d early_ready=%0d, want 1/0", fe_seen, ready_seen);
        end
        drive(1'b1, TERM, 1'b0);
        pop();
        tests++;
        if ({bus.rd_valid, bus.rd_data, bus.msg_ready} !== {1'b1, 8'h43, 1'b0}) begin
            fails++;
            $display("FAIL frame_err_msg_c: got rdv=%0b data=%h ready=%0b, want 1/43/0", bus.rd_valid, bus.rd_data, bus.msg_ready);
        end
        drive(1'b1, 8'h44, 1'b1);
        drive(1'b1, TERM, 1'b0);
        tests++;
        if ({bus.msg_ready, bus.frame_err} !== 2'b00) begin
            fails++;
            $display("FAIL err_wins_over_byte: got ready=%0b fe=%0b, want 0/0", bus.msg_ready, bus.frame_err);
        end
    endtask

    task automatic test_rx_drop();
        drive(1'b1, 8'h31, 1'b0);
        drive(1'b1, 8'h32, 1'b0);
        drive(1'b1, TERM, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        tests++;
        if ({bus.rx_drop, bus.msg_ready, bus.msg_len} !== {1'b1, 1'b1, 5'd2}) begin
            fails++;
            $display("FAIL rx_drop_pulse: got drop=%0b ready=%0b len=%0d, want 1/1/2", bus.rx_drop, bus.msg_ready, bus.msg_len);
        end
        drive(1'b0, 8'h00, 1'b1);
        tests++;
        if ({bus.rx_drop, bus.frame_err, bus.msg_ready} !== 3'b001) begin
            fails++;
            $display("FAIL ready_err_ignored: got drop=%0b fe=%0b ready=%0b, want 0/0/1", bus.rx_drop, bus.frame_err, bus.msg_ready);
        end
        pop();
        tests++;
        if (bus.rd_data !== 8'h31) begin
            fails++;
            $display("FAIL rx_drop_byte0: got %h, want 31", bus.rd_data);
        end
        pop();
        tests++;
        if ({bus.rd_data, bus.msg_ready} !== {8'h32, 1'b0}) begin
            fails++;
            $display("FAIL rx_drop_byte1: got data=%h ready=%0b, want 32/0", bus.rd_data, bus.msg_ready);
        end
    endtask

    task automatic test_timeout();
        int first_at = -1;
        int pulses = 0;
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b1, 8'h42, 1'b0);
        for (int k = 1; k <= TO_CYC + 20; k++) begin
            tick();
            if (bus.timeout === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
`ifdef MSG_RX_TIMEOUT_EN
        tests++;
        if (first_at != TO_CYC || pulses != 1) begin
            fails++;
            $display("FAIL timeout_pulse: got at=%0d count=%0d, want %0d/1", first_at, pulses, TO_CYC);
        end
        drive(1'b1, TERM, 1'b0);
        tests++;
        if (bus.msg_ready !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got ready=%0b, want 0", bus.msg_ready);
        end
`else
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL timeout_absent: got %0d pulses, want 0", pulses);
        end
        drive(1'b1, TERM, 1'b0);
        tests++;
        if ({bus.msg_ready, bus.msg_len} !== {1'b1, 5'd2}) begin
            fails++;
            $display("FAIL no_timeout_msg: got ready=%0b len=%0d, want 1/2", bus.msg_ready, bus.msg_len);
        end
        pop();
        pop();
`endif
    endtask

    task automatic test_random();
        bit ovf, fe, drop, v, e;
        logic [7:0] d, exp_b;
        logic [11:0] got, exp;
        cur_q.delete(); held_q.delete(); disc = 1'b0; held_len = 0;
        for (int m = 0; m < 40; m++) begin
            int len = $urandom_range(1, MAX_LEN + 2);
            for (int i = 0; i <= len; i++) begin
                e = ($urandom_range(0, 24) == 0);
                v = e ? 1'($urandom_range(0, 1)) : 1'b1;
                d = (i == len) ? TERM : rand_byte();
                if (i == len) e = 1'b0;
                if (i == len) v = 1'b1;
                drive(v, d, e);
                model_rx(v, d, e, ovf, fe, drop);
                got = {bus.overflow, bus.frame_err, bus.rx_drop, bus.msg_ready, bus.timeout, 2'b00, bus.msg_len};
                exp = {ovf, fe, drop, held_q.size() != 0, 1'b0, 2'b00,
                       (held_q.size() != 0) ? 5'(held_len) : 5'd0};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL rand_rx m=%0d i=%0d: got %b, want %b (ovf,fe,drop,ready,to,00,len)", m, i, got, exp);
                end
            end
            if (held_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                d = rand_byte();
                drive(1'b1, d, 1'b0);
                model_rx(1'b1, d, 1'b0, ovf, fe, drop);
                tests++;
                if ({bus.rx_drop, bus.msg_ready} !== {drop, 1'b1}) begin
                    fails++;
                    $display("FAIL rand_drop m=%0d: got drop=%0b ready=%0b, want %0b/1", m, bus.rx_drop, bus.msg_ready, drop);
                end
            end
            while (held_q.size() != 0) begin
                repeat ($urandom_range(0, 2)) tick();
                pop();
                exp_b = held_q.pop_front();
                tests++;
                if ({bus.rd_valid, bus.rd_data, bus.msg_ready} !== {1'b1, exp_b, held_q.size() != 0}) begin
                    fails++;
                    $display("FAIL rand_pop m=%0d: got rdv=%0b data=%h ready=%0b, want 1/%h/%0b",
                             m, bus.rd_valid, bus.rd_data, bus.msg_ready, exp_b, held_q.size() != 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h58, 1'b0);
        drive(1'b1, 8'h59, 1'b0);
        drive(1'b1, TERM, 1'b0);
        pop();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.msg_ready, bus.msg_len, bus.rd_valid, bus.rd_data} !== 15'd0) begin
            fails++;
            $display("FAIL async_reset_ready: got ready=%0b len=%0d rdv=%0b data=%h, want all 0",
                     bus.msg_ready, bus.msg_len, bus.rd_valid, bus.rd_data);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 8'h61, 1'b0);
        drive(1'b1, 8'h62, 1'b0);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, TERM, 1'b0);
        tests++;
        if ({bus.msg_ready, bus.msg_len} !== 6'd0) begin
            fails++;
            $display("FAIL reset_mid_collect: got ready=%0b len=%0d after lone terminator, want 0/0", bus.msg_ready, bus.msg_len);
        end
        drive(1'b1, 8'h51, 1'b0);
        drive(1'b1, TERM, 1'b0);
        pop();
        tests++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h51}) begin
            fails++;
            $display("FAIL post_reset_msg: got rdv=%0b data=%h, want 1/51", bus.rd_valid, bus.rd_data);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_err   = 1'b0;
        bus.rd_en    = 1'b0;
        test_reset();
        test_hi();
        test_overflow();
        test_frame_err();
        test_rx_drop();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/msg_assembler.md
MSG_ASSEMBLER -- requirements
Module: msg_assembler

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per message (2..256).
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0D: end-of-message byte, never stored.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: inter-byte idle limit in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-007 SHALL have port rx_data  input  8  received byte.
REQ-008 SHALL have port rx_err  input  1  one-cycle framing-error strobe from the UART receiver.
REQ-009 SHALL have port rd_en  input  1  consumer pop request.
REQ-010 SHALL have port msg_ready  output  1  complete message held, readable.
REQ-011 SHALL have port msg_len  output  $clog2(MAX_LEN+1)  payload length of the held message.
REQ-012 SHALL have port rd_data  output  8  popped byte, registered.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-014 SHALL have ports overflow, frame_err, rx_drop, timeout  output  1 each  one-cycle event pulses.

Function
REQ-015 SHALL implement states IDLE, COLLECT, READY, DISCARD, 2-bit encoded.
REQ-016 IDLE: rx_valid with byte != TERM_CHAR SHALL store it at index 0, set count=1, go COLLECT; TERM_CHAR in IDLE SHALL be ignored (no empty messages).
REQ-017 COLLECT: non-terminator byte with count<MAX_LEN SHALL be stored at index count, count+1.
REQ-018 COLLECT: non-terminator byte with count==MAX_LEN SHALL pulse overflow, go DISCARD.
REQ-019 COLLECT: TERM_CHAR SHALL go READY; msg_ready and msg_len=count SHALL assert the cycle after the terminator's strobe.
REQ-020 rx_err in IDLE or COLLECT SHALL pulse frame_err and go DISCARD; rx_err with rx_valid in the same cycle SHALL discard that byte (error wins).
REQ-021 DISCARD: SHALL drop all bytes until TERM_CHAR, then go IDLE; msg_ready SHALL not assert.
REQ-022 READY: rd_en SHALL output byte rd_ptr on rd_data with rd_valid one cycle later, rd_ptr+1; rd_en outside READY SHALL be ignored.
REQ-023 READY: pop of byte msg_len-1 SHALL go IDLE; msg_ready and msg_len SHALL deassert/clear the following cycle.
REQ-024 READY: any rx_valid SHALL pulse rx_drop and not alter the held message; rx_err SHALL be ignored.
REQ-025 Event pulses SHALL be registered, high exactly one cycle per event.

Reset
REQ-026 rst_n low SHALL force IDLE, count=0, rd_ptr=0, all outputs 0, regardless of state; buffer contents need not clear.

Configuration
REQ-027 With MSG_RX_TIMEOUT_EN defined: in COLLECT an idle counter SHALL reset on each rx_valid and, at TIMEOUT_CYC cycles without a byte, pulse timeout, discard the partial message, go IDLE.
REQ-028 Without MSG_RX_TIMEOUT_EN: no counter SHALL be built; timeout SHALL be tied 0; COLLECT waits indefinitely.

Structure
REQ-029 State encodings and default TERM_CHAR/MAX_LEN constants SHALL live in shared package msg_pkg, shared with the transmit-side message FSM.
REQ-030 Byte storage SHALL be sub-module msg_buffer: MAX_LEN x 8 simple dual-port, one write port, registered read port.

Verification
REQ-031 Send 'H','I',0x0D -> msg_ready=1, msg_len=2 next cycle; two rd_en -> rd_data 0x48 then 0x49 with rd_valid; IDLE after.
REQ-032 MAX_LEN=16, send 17 non-terminator bytes -> overflow pulse on 17th; then 0x0D -> IDLE, msg_ready never asserts.
REQ-033 'A', rx_err, 'B', 0x0D, 'C', 0x0D -> frame_err pulse; only message 'C', msg_len=1.
REQ-034 Byte 0x55 while READY -> rx_drop pulse; popped contents unchanged.
REQ-035 Macro defined, TIMEOUT_CYC=100: 'A','B' then 100 idle cycles -> timeout pulse, IDLE; macro undefined -> no pulse, later 0x0D yields msg_len=2.
REQ-036 rst_n low mid-COLLECT -> all outputs 0, IDLE; lone 0x0D then -> no msg_ready.
